// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkg: shared pointer types and helpers for the async FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int SIZE_DEF   = 4;
  localparam int DATA_W_DEF = 8;
  localparam int PTR_MAX_W  = 16;

  typedef logic [SIZE_DEF-1:0] ptr_t;

  // Modular distance wr - rd over a pointer of 'size' bits (size <= PTR_MAX_W).
  function automatic logic [PTR_MAX_W-1:0] ptr_distance(
    input logic [PTR_MAX_W-1:0] wr,
    input logic [PTR_MAX_W-1:0] rd,
    input int unsigned          size
  );
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << size) - PTR_MAX_W'(1);
    return (wr - rd) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_out_skid.sv
//------------------------------------------------------------------------------
// fifo_out_skid: 2-entry valid/ready output buffer; head entry drives out_data.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic [1:0]        occ,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop;

  assign pop       = out_ready && (occ_q != 2'd0);
  assign occ       = occ_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the incoming word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
//------------------------------------------------------------------------------
// fifo_read_ctrl: read-side controller of the async FIFO (destination domain).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              dest_clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   wr_ptr_sync,
  output logic [SIZE-1:0]   rd_ptr_bin,
  output logic              mem_rd_en,
  output logic [SIZE-2:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              empty,
  output logic              almost_empty,
  output logic [SIZE-1:0]   fill_level,
  output logic              ptr_err
);

  localparam logic [SIZE-1:0] C_DEPTH = {1'b1, {(SIZE-1){1'b0}}};

  logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [SIZE-1:0] fill_q, fill_d;
  logic [SIZE-1:0] count;
  logic            inflight_q;
  logic            empty_q, empty_d;
  logic            almost_empty_q, almost_empty_d;
  logic            ptr_err_q, ptr_err_d;
  logic            ptr_illegal;
  logic            rd_en;
  logic            pop;
  logic [1:0]      occ;
  logic [1:0]      occ_after_pop;

  assign count       = SIZE'(ptr_distance(PTR_MAX_W'(wr_ptr_sync), PTR_MAX_W'(rd_ptr_q), SIZE));
  assign ptr_illegal = (count > C_DEPTH);

  // Occupancy is counted after this cycle's pop so a full-rate stream keeps issuing.
  assign pop           = out_valid && out_ready;
  assign occ_after_pop = occ - {1'b0, pop};
  assign rd_en         = !rst && (count != '0) && !ptr_illegal
                         && ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

  assign mem_rd_en    = rd_en;
  assign mem_rd_addr  = rd_ptr_q[SIZE-2:0];
  assign rd_ptr_bin   = rd_ptr_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign fill_level   = fill_q;
  assign ptr_err      = ptr_err_q;

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    fill_d         = count;
    empty_d        = (count == '0);
    almost_empty_d = (int'(count) <= ALMOST_EMPTY);
    ptr_err_d      = ptr_err_q || ptr_illegal;
  end

  // Clearing inflight_q on reset drops any RAM word still on its way back.
  always_ff @(posedge dest_clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      fill_q         <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      ptr_err_q      <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      inflight_q     <= rd_en;
      fill_q         <= fill_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      ptr_err_q      <= ptr_err_d;
    end
  end

  fifo_out_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (dest_clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem_rd_data),
    .occ       (occ),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
//------------------------------------------------------------------------------
// tb_fifo_read_ctrl: directed bench with a 1-cycle RAM model and data scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_read_ctrl;

  localparam int SIZE   = 4;
  localparam int DATA_W = 8;

  logic              dest_clk = 1'b0;
  logic              rst;
  logic [SIZE-1:0]   wr_ptr_sync;
  logic [SIZE-1:0]   rd_ptr_bin;
  logic              mem_rd_en;
  logic [SIZE-2:0]   mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              empty;
  logic              almost_empty;
  logic [SIZE-1:0]   fill_level;
  logic              ptr_err;

  fifo_read_ctrl #(
    .SIZE         (SIZE),
    .DATA_W       (DATA_W),
    .ALMOST_EMPTY (2)
  ) dut (
    .dest_clk     (dest_clk),
    .rst          (rst),
    .wr_ptr_sync  (wr_ptr_sync),
    .rd_ptr_bin   (rd_ptr_bin),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .fill_level   (fill_level),
    .ptr_err      (ptr_err)
  );

  always #5 dest_clk = ~dest_clk;

  logic [DATA_W-1:0] ram [8];
  always @(posedge dest_clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  int              n_chk;
  int              n_fail;
  int              rd_cnt;
  int              n_extra;
  logic [7:0]      exp_q[$];
  logic [2:0]      addr_log[$];
  logic [3:0]      cur_wr;
  logic            hold_prev;
  logic [7:0]      hold_data;
  logic            s_en, s_valid, s_err, s_empty, s_ae;
  logic [3:0]      s_fill, s_rdptr;
  logic [7:0]      s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after a negedge, check handshakes, then advance one cycle.
  task automatic tick();
    #1;
    s_en = mem_rd_en; s_valid = out_valid; s_err = ptr_err; s_empty = empty;
    s_ae = almost_empty; s_fill = fill_level; s_rdptr = rd_ptr_bin; s_data = out_data;
    if (mem_rd_en) begin
      rd_cnt++;
      addr_log.push_back(mem_rd_addr);
    end
    if (hold_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(hold_data));
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) n_extra++;
      else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    @(posedge dest_clk);
    @(negedge dest_clk);
  endtask

  task automatic advance(input logic [3:0] nw);
    while (cur_wr != nw) begin
      exp_q.push_back(8'hA0 + {5'd0, cur_wr[2:0]});
      cur_wr = cur_wr + 4'd1;
    end
    wr_ptr_sync = nw;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_ptr_sync = '0;
    cur_wr = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
  endtask

  function automatic logic [31:0] pack_addrs();
    logic [31:0] v;
    v = '0;
    foreach (addr_log[i]) v = (v << 3) | 32'(addr_log[i]);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] en_hist, val_hist;
    logic [3:0]  fill_hist [8];
    logic        any_valid;

    n_chk = 0; n_fail = 0; rd_cnt = 0; n_extra = 0;
    hold_prev = 1'b0; hold_data = '0;
    for (int i = 0; i < 8; i++) ram[i] = 8'hA0 + 8'(i);

    // 1: reset with pointer held at 3, then drain three words in order.
    rst = 1'b1; wr_ptr_sync = 4'h3; out_ready = 1'b0; cur_wr = 4'h0;
    tick();
    chk("rst_rd_en", 32'(s_en), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_rdptr", 32'(s_rdptr), 32'd0);
    chk("rst_fill", 32'(s_fill), 32'd0);
    chk("rst_almost_empty", 32'(s_ae), 32'd1);
    chk("rst_ptr_err", 32'(s_err), 32'd0);
    chk("rst_out_data", 32'(s_data), 32'd0);
    tick();
    chk("rst_rd_en2", 32'(s_en), 32'd0);
    advance(4'h3);
    rst = 1'b0; out_ready = 1'b1; rd_cnt = 0; addr_log.delete();
    drain("t1_drain");
    tick(); tick();
    chk("t1_reads", rd_cnt, 32'd3);
    chk("t1_addrs", pack_addrs(), 32'h00A);
    chk("t1_empty", 32'(s_empty), 32'd1);
    chk("t1_almost_empty", 32'(s_ae), 32'd1);
    chk("t1_rdptr", 32'(s_rdptr), 32'h3);

    // 2: full burst with consumer always ready.
    do_reset();
    out_ready = 1'b1; rd_cnt = 0;
    advance(4'h8);
    for (int i = 0; i < 12; i++) begin
      tick();
      en_hist[i]  = s_en;
      val_hist[i] = s_valid;
    end
    chk("t2_rd_en_pattern", 32'(en_hist), 32'h0FF);
    chk("t2_valid_pattern", 32'(val_hist), 32'h3FC);
    chk("t2_rdptr", 32'(s_rdptr), 32'h8);
    chk("t2_queue", exp_q.size(), 32'd0);

    // 3: consumer stalled, only two words prefetched; then release.
    do_reset();
    out_ready = 1'b0; rd_cnt = 0;
    advance(4'h8);
    for (int i = 0; i < 6; i++) tick();
    chk("t3_stall_reads", rd_cnt, 32'd2);
    chk("t3_valid", 32'(s_valid), 32'd1);
    chk("t3_head", 32'(s_data), 32'hA0);
    chk("t3_fill", 32'(s_fill), 32'd6);
    chk("t3_empty", 32'(s_empty), 32'd0);
    chk("t3_almost_empty", 32'(s_ae), 32'd0);
    out_ready = 1'b1;
    drain("t3_drain");
    tick();
    chk("t3_reads", rd_cnt, 32'd8);
    chk("t3_rdptr", 32'(s_rdptr), 32'h8);

    // 4: pointer wrap from E to 2.
    do_reset();
    out_ready = 1'b1;
    advance(4'h8);
    drain("t4_pre1");
    advance(4'hE);
    drain("t4_pre2");
    tick();
    chk("t4_start_rdptr", 32'(s_rdptr), 32'hE);
    rd_cnt = 0; addr_log.delete();
    advance(4'h2);
    for (int i = 0; i < 8; i++) begin
      tick();
      fill_hist[i] = s_fill;
    end
    chk("t4_reads", rd_cnt, 32'd4);
    chk("t4_addrs", pack_addrs(), 32'hDC1);
    chk("t4_fill_first", 32'(fill_hist[1]), 32'd4);
    chk("t4_fill_last", 32'(fill_hist[5]), 32'd0);
    chk("t4_rdptr", 32'(s_rdptr), 32'h2);
    chk("t4_queue", exp_q.size(), 32'd0);

    // 5: illegal distance of 9 sets the sticky error.
    wr_ptr_sync = 4'hB;
    tick();
    chk("t5_no_read", 32'(s_en), 32'd0);
    chk("t5_err_lag", 32'(s_err), 32'd0);
    wr_ptr_sync = 4'h2;
    tick();
    chk("t5_err_set", 32'(s_err), 32'd1);
    tick(); tick(); tick();
    chk("t5_err_hold", 32'(s_err), 32'd1);
    chk("t5_rdptr", 32'(s_rdptr), 32'h2);
    do_reset();
    tick();
    chk("t5_err_cleared", 32'(s_err), 32'd0);

    // 6: reset while a RAM read is in flight.
    out_ready = 1'b1;
    wr_ptr_sync = 4'h1;
    tick();
    chk("t6_issue", 32'(s_en), 32'd1);
    rst = 1'b1; wr_ptr_sync = 4'h0;
    tick();
    chk("t6_rst_valid", 32'(s_valid), 32'd0);
    chk("t6_rst_rdptr", 32'(s_rdptr), 32'd0);
    rst = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_valid = any_valid | s_valid;
    end
    chk("t6_no_valid", 32'(any_valid), 32'd0);
    chk("t6_out_data", 32'(s_data), 32'd0);
    chk("extra_outputs", n_extra, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
